master_rx: RTL

Master-side receiver for the single-wire-request serial link whose slave end streams FIFO data out on `miso`. It waits for the slave's `rdy` and a local `start`, then holds `mosi` low for one block. It samples `miso` LSB-first, reassembles bytes and writes them to a downstream byte sink. It shares `clk` with the slave interface; there is no synchronizer on `miso` or `rdy`.

---
 rtl/master_rx.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/master_rx.sv
// master_rx: master-side receiver for the single-wire-request serial link.
// Waits for a local start while the slave reports rdy, pulls mosi low for one
// block, samples miso LSB-first, reassembles bytes and strobes them into a
// downstream byte sink. Shares clk with the slave, so miso/rdy are used
// directly without synchronizers.
//
// Ports:
//   clk      in   single clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   request one block (sampled in IDLE only)
//   rdy      in   slave has at least BLOCKSIZE bits buffered
//   miso     in   serial data from slave, LSB first
//   wfull    in   downstream sink full
//   mosi     out  request line, low while a transfer is active
//   wdata    out  assembled byte
//   wr       out  one-cycle write strobe for wdata
//   busy     out  transfer in progress (LEAD/SHIFT/GAP)
//   done     out  one-cycle pulse at end of block
//   ovf      out  sticky: a byte was written while wfull was high
//   bytecnt  out  bytes written in the current/last transfer
module master_rx #(
  parameter int BLOCKSIZE = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rdy,
  input  logic        miso,
  input  logic        wfull,
  output logic        mosi,
  output logic [7:0]  wdata,
  output logic        wr,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [10:0] bytecnt
);

  localparam int NB = BLOCKSIZE / 8;
  localparam logic [10:0] LAST_BYTE = 11'(NB - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [1:0]  lead_r, lead_s;     // LEAD latency counter, reused to time GAP
  logic [2:0]  bit_r, bit_s;
  logic [7:0]  sr_r, sr_s;
  logic        mosi_s;
  logic [7:0]  wdata_s;
  logic        wr_s;
  logic        busy_s;
  logic        done_s;
  logic        ovf_s;
  logic [10:0] bytecnt_s;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s   = state_r;
    lead_s    = lead_r;
    bit_s     = bit_r;
    sr_s      = sr_r;
    mosi_s    = mosi;
    wdata_s   = wdata;
    wr_s      = 1'b0;
    done_s    = 1'b0;
    ovf_s     = ovf;
    bytecnt_s = bytecnt;
    case (state_r)
      IDLE: begin
        mosi_s = 1'b1;
        if (start && rdy && !wfull) begin
          mosi_s    = 1'b0;
          lead_s    = 2'd0;
          bit_s     = 3'd0;
          bytecnt_s = 11'd0;
          ovf_s     = 1'b0;
          state_s   = LEAD;
        end else begin
          state_s = IDLE;
        end
      end
      LEAD: begin
        // Third LEAD edge lines bit 0 of byte 0 up with the following edge.
        lead_s = lead_r + 2'd1;
        if (lead_r == 2'd2) begin
          state_s = SHIFT;
        end else begin
          state_s = LEAD;
        end
      end
      SHIFT: begin
        sr_s  = {miso, sr_r[7:1]};
        bit_s = bit_r + 3'd1;
        if (bit_r == 3'd7) begin
          // Data is never stalled: a full sink only raises the sticky flag.
          wdata_s   = {miso, sr_r[7:1]};
          wr_s      = 1'b1;
          bytecnt_s = bytecnt + 11'd1;
          if (wfull) begin
            ovf_s = 1'b1;
          end else begin
            ovf_s = ovf;
          end
          if (bytecnt == LAST_BYTE) begin
            mosi_s  = 1'b1;
            done_s  = 1'b1;
            lead_s  = 2'd0;
            state_s = GAP;
          end else begin
            state_s = SHIFT;
          end
        end else begin
          state_s = SHIFT;
        end
      end
      GAP: begin
        // Two edges with mosi high let the slave fall back to idle.
        mosi_s = 1'b1;
        lead_s = lead_r + 2'd1;
        if (lead_r == 2'd1) begin
          state_s = IDLE;
        end else begin
          state_s = GAP;
        end
      end
      default: begin
        mosi_s  = 1'b1;
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      lead_r  <= 2'd0;
      bit_r   <= 3'd0;
      sr_r    <= 8'd0;
      mosi    <= 1'b1;
      wdata   <= 8'd0;
      wr      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      bytecnt <= 11'd0;
    end else begin
      state_r <= state_s;
      lead_r  <= lead_s;
      bit_r   <= bit_s;
      sr_r    <= sr_s;
      mosi    <= mosi_s;
      wdata   <= wdata_s;
      wr      <= wr_s;
      busy    <= busy_s;
      done    <= done_s;
      ovf     <= ovf_s;
      bytecnt <= bytecnt_s;
    end
  end

endmodule
